multicycle_controller: RTL
==========================

# multicycle_controller

Multi-cycle control unit for the IITK Mini-MIPS datapath. It is the FSM successor to the single-cycle decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states, and waits on a variable-latency memory via `mem_ready`. It extends the ISA with bne, andi, ori, slti, lui and jal, and traps on illegal encodings. It sits between the instruction register (IR) and the shared-memory, ALU and register-file datapath.

## Interface
- `ALU_CTRL_W`, default 4: ALU control width; must be ≥4; codes are zero-extended.
- `ENABLE_EXT`, default 1: when 0, bne/andi/ori/slti/lui/jal decode as illegal.
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  IR[31:26]; stable from DECODE until the return to FETCH.
- `funct`  in  6  IR[5:0]; same stability rule as `opcode`.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `pc_write`, `pc_write_cond`, `ir_write`, `iord`, `mem_read`, `mem_write`, `reg_write`, `alu_src_a`, `branch_ne`  out  1 each  datapath strobes and selects.
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- `reg_dst`  out  2  00 = rt, 01 = rd, 10 = r31.
- `mem_to_reg`  out  2  00 = ALUOut, 01 = MDR, 10 = PC.
- `alu_src_b`  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_control`  out  `ALU_CTRL_W`  ALU operation code.
- `instr_done`  out  1  one-cycle pulse in an instruction's final state.
- `illegal`  out  1  sticky trap flag.
- `state`  out  4  current state, for debug.

## Operation
- ALU codes: and 0, or 1, add 2, sub 3, xor 4, not 5, sll 6, srl 7, sra 8, slt 9, seq 10, lui 11.
- Outputs are decoded from the state register plus `opcode`/`funct`. Every output not listed for a state is 0.

State actions and transitions:
- **FETCH (0):** `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, ALU add. `ir_write` and `pc_write` are each asserted only when `mem_ready`=1. Stay in FETCH while `mem_ready`=0; go to DECODE on `mem_ready`=1.
- **DECODE (1):** `alu_src_b`=11, ALU add (precomputes the branch target). Next state by opcode:
  - lw/sw → MEM_ADDR.
  - R-type → R_EXEC.
  - beq/bne → BRANCH.
  - j/jal → JUMP.
  - addi/andi/ori/slti/lui → I_EXEC.
  - anything else → TRAP.
- **MEM_ADDR (2):** `alu_src_a`=1, `alu_src_b`=10, ALU add. lw → MEM_READ; sw → MEM_WRITE.
- **MEM_READ (3):** `mem_read`=1, `iord`=1. Hold until `mem_ready`, then go to MEM_WB.
- **MEM_WB (4):** `reg_write`=1, `reg_dst`=00, `mem_to_reg`=01. Go to FETCH.
- **MEM_WRITE (5):** `mem_write`=1, `iord`=1. Hold until `mem_ready`, then go to FETCH.
- **R_EXEC (6):** `alu_src_a`=1, `alu_src_b`=00, ALU code taken from `funct`. Go to R_WB. An unknown `funct` is caught at DECODE and goes to TRAP.
- **R_WB (7):** `reg_write`=1, `reg_dst`=01, `mem_to_reg`=00. Go to FETCH.
- **BRANCH (8):** `alu_src_a`=1, `alu_src_b`=00, ALU sub, `pc_write_cond`=1, `pc_src`=01, `branch_ne`=1 for bne. Go to FETCH.
- **JUMP (9):** `pc_write`=1, `pc_src`=10. For jal, also `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10. Go to FETCH.
- **I_EXEC (10):** `alu_src_a`=1, `alu_src_b`=10. ALU code: addi → add, andi → and, ori → or, slti → slt, lui → lui. Go to I_WB.
- **I_WB (11):** `reg_write`=1, `reg_dst`=00, `mem_to_reg`=00. Go to FETCH.
- **TRAP (12):** `illegal`=1. All write strobes and `mem_read` are 0. Stays in TRAP until reset.

Other rules:
- `instr_done` pulses in MEM_WB, in MEM_WRITE when `mem_ready`=1, in R_WB, BRANCH, JUMP and I_WB.

## Timing
- Reset: `state`=FETCH immediately, asynchronously.
- Outputs while in reset equal the FETCH decode: `mem_read`=1, `alu_src_b`=01, `alu_control`=2. `pc_write` and `ir_write` follow `mem_ready`. All other outputs are 0, including `illegal`.
- If reset asserts mid-instruction, the FSM aborts to FETCH in the same cycle and no further writes are issued.
- Minimum cycles with `mem_ready` tied high: lw 5; sw, R-type and I-type 4; beq/bne and j/jal 3.
- Each cycle with `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- `mem_ready` has no effect in any other state.

## Structure
- Shared package `mips_ctrl_pkg`: opcode and funct localparams, the ALU code enum, the state enum (4-bit), and the `pc_src`, `reg_dst` and `mem_to_reg` encodings.
- Sub-module `alu_decoder` (combinational): maps opcode, funct and state class to an ALU code plus a `valid` flag. The FSM uses `valid` to route to TRAP at DECODE.

## Test plan
- lw (opcode 0x23), `mem_ready` high → states 0,1,2,3,4. `reg_write`=1 with `mem_to_reg`=01 in cycle 5; `instr_done` pulses once.
- sw with `mem_ready` low for 3 cycles in MEM_WRITE → `mem_write` held 4 cycles; FETCH entered on cycle 8.
- R-type funct 0x22 → `alu_control`=3 in R_EXEC; then R_WB with `reg_dst`=01. Funct 0x3F → `illegal`=1 and sticky; no `reg_write` ever.
- bne (0x05) → BRANCH with `pc_write_cond`=1, `branch_ne`=1, `alu_control`=3. jal (0x03) → `reg_dst`=10, `mem_to_reg`=10, `pc_src`=10.
- `ENABLE_EXT`=0 with lui (0x0F) → TRAP. `ENABLE_EXT`=1 with lui → `alu_control`=11 in I_EXEC.
- `rst_n` dropped during MEM_READ → `state`=0 asynchronously and `mem_read` with `iord`=0. `illegal` is cleared.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - Shared encodings for the Mini-MIPS multi-cycle controller
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0, ALU_OR  = 4'd1, ALU_ADD = 4'd2,  ALU_SUB = 4'd3,
    ALU_XOR = 4'd4, ALU_NOT = 4'd5, ALU_SLL = 4'd6,  ALU_SRL = 4'd7,
    ALU_SRA = 4'd8, ALU_SLT = 4'd9, ALU_SEQ = 4'd10, ALU_LUI = 4'd11
  } alu_op_t;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,  S_DECODE  = 4'd1,  S_MEM_ADDR = 4'd2,
    S_MEM_READ = 4'd3,  S_MEM_WB  = 4'd4,  S_MEM_WRITE = 4'd5,
    S_R_EXEC   = 4'd6,  S_R_WB    = 4'd7,  S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,  S_I_EXEC  = 4'd10, S_I_WB     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  // Which operand source drives the ALU code in the current state
  typedef enum logic [2:0] {
    ALU_CLS_NONE, ALU_CLS_ADD, ALU_CLS_SUB, ALU_CLS_FUNCT, ALU_CLS_IMM
  } alu_class_t;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] REG_DST_RT  = 2'b00;
  localparam logic [1:0] REG_DST_RD  = 2'b01;
  localparam logic [1:0] REG_DST_R31 = 2'b10;

  localparam logic [1:0] MEM_TO_REG_ALUOUT = 2'b00;
  localparam logic [1:0] MEM_TO_REG_MDR    = 2'b01;
  localparam logic [1:0] MEM_TO_REG_PC     = 2'b10;

  localparam logic [1:0] ALU_SRC_B_REG     = 2'b00;
  localparam logic [1:0] ALU_SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_SRC_B_IMM_SH2 = 2'b11;

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - IR/memory inputs and datapath control strobes
interface multicycle_controller_if #(
  parameter int ALU_CTRL_W = 4
);
  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic                  mem_ready;
  logic                  pc_write;
  logic                  pc_write_cond;
  logic                  ir_write;
  logic                  iord;
  logic                  mem_read;
  logic                  mem_write;
  logic                  reg_write;
  logic                  alu_src_a;
  logic                  branch_ne;
  logic [1:0]            pc_src;
  logic [1:0]            reg_dst;
  logic [1:0]            mem_to_reg;
  logic [1:0]            alu_src_b;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic                  instr_done;
  logic                  illegal;
  logic [3:0]            state;

  modport master (
    input  opcode, funct, mem_ready,
    output pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
           reg_write, alu_src_a, branch_ne, pc_src, reg_dst, mem_to_reg,
           alu_src_b, alu_control, instr_done, illegal, state
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
           reg_write, alu_src_a, branch_ne, pc_src, reg_dst, mem_to_reg,
           alu_src_b, alu_control, instr_done, illegal, state
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// rtl/multicycle_controller_alu_decoder.sv - ALU code selection and instruction legality check
module alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter bit ENABLE_EXT = 1'b1
) (
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  alu_class_t  alu_class,
  output alu_op_t     alu_op,
  output logic        valid
);

  alu_op_t r_op;
  logic    r_ok;
  alu_op_t i_op;

  always_comb begin
    r_op = ALU_ADD;
    r_ok = 1'b1;
    case (funct)
      FN_SLL:  r_op = ALU_SLL;
      FN_SRL:  r_op = ALU_SRL;
      FN_SRA:  r_op = ALU_SRA;
      FN_ADD:  r_op = ALU_ADD;
      FN_SUB:  r_op = ALU_SUB;
      FN_AND:  r_op = ALU_AND;
      FN_OR:   r_op = ALU_OR;
      FN_XOR:  r_op = ALU_XOR;
      FN_NOR:  r_op = ALU_NOT;
      FN_SLT:  r_op = ALU_SLT;
      default: r_ok = 1'b0;
    endcase
  end

  always_comb begin
    i_op = ALU_ADD;
    case (opcode)
      OP_ANDI: i_op = ALU_AND;
      OP_ORI:  i_op = ALU_OR;
      OP_SLTI: i_op = ALU_SLT;
      OP_LUI:  i_op = ALU_LUI;
      default: i_op = ALU_ADD;
    endcase
  end

  // Extension opcodes are only legal when the extended ISA is built in
  always_comb begin
    valid = 1'b0;
    case (opcode)
      OP_RTYPE:                                    valid = r_ok;
      OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI:         valid = 1'b1;
      OP_BNE, OP_JAL, OP_ANDI, OP_ORI, OP_SLTI,
      OP_LUI:                                      valid = ENABLE_EXT;
      default:                                     valid = 1'b0;
    endcase
  end

  always_comb begin
    alu_op = ALU_AND;
    case (alu_class)
      ALU_CLS_ADD:   alu_op = ALU_ADD;
      ALU_CLS_SUB:   alu_op = ALU_SUB;
      ALU_CLS_FUNCT: alu_op = r_op;
      ALU_CLS_IMM:   alu_op = i_op;
      default:       alu_op = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Multi-cycle Mini-MIPS control FSM with memory wait states and trap
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4,
  parameter bit ENABLE_EXT = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master bus
);

  state_t     state_q;
  alu_class_t alu_class;
  alu_op_t    alu_op;
  logic       instr_valid;

  alu_decoder #(.ENABLE_EXT(ENABLE_EXT)) u_alu_decoder (
    .opcode    (bus.opcode),
    .funct     (bus.funct),
    .alu_class (alu_class),
    .alu_op    (alu_op),
    .valid     (instr_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:     if (bus.mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          if (!instr_valid) begin
            state_q <= S_TRAP;
          end else begin
            case (bus.opcode)
              OP_LW, OP_SW:   state_q <= S_MEM_ADDR;
              OP_RTYPE:       state_q <= S_R_EXEC;
              OP_BEQ, OP_BNE: state_q <= S_BRANCH;
              OP_J, OP_JAL:   state_q <= S_JUMP;
              default:        state_q <= S_I_EXEC;
            endcase
          end
        end
        S_MEM_ADDR:  state_q <= (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  if (bus.mem_ready) state_q <= S_MEM_WB;
        S_MEM_WRITE: if (bus.mem_ready) state_q <= S_FETCH;
        S_R_EXEC:    state_q <= S_R_WB;
        S_I_EXEC:    state_q <= S_I_WB;
        S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB:
                     state_q <= S_FETCH;
        S_TRAP:      state_q <= S_TRAP;
        default:     state_q <= S_TRAP;
      endcase
    end
  end

  always_comb begin
    alu_class = ALU_CLS_NONE;
    case (state_q)
      S_FETCH, S_DECODE, S_MEM_ADDR: alu_class = ALU_CLS_ADD;
      S_R_EXEC:                      alu_class = ALU_CLS_FUNCT;
      S_BRANCH:                      alu_class = ALU_CLS_SUB;
      S_I_EXEC:                      alu_class = ALU_CLS_IMM;
      default:                       alu_class = ALU_CLS_NONE;
    endcase
  end

  assign bus.alu_control = ALU_CTRL_W'(alu_op);
  assign bus.state       = state_q;

  // Strobes are a pure decode of the state register so reset yields the FETCH pattern at once
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.ir_write      = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.branch_ne     = 1'b0;
    bus.pc_src        = PC_SRC_ALU;
    bus.reg_dst       = REG_DST_RT;
    bus.mem_to_reg    = MEM_TO_REG_ALUOUT;
    bus.alu_src_b     = ALU_SRC_B_REG;
    bus.instr_done    = 1'b0;
    bus.illegal       = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = ALU_SRC_B_FOUR;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      S_DECODE:   bus.alu_src_b = ALU_SRC_B_IMM_SH2;
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = ALU_SRC_B_IMM;
      end
      S_MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = MEM_TO_REG_MDR;
        bus.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        bus.mem_write  = 1'b1;
        bus.iord       = 1'b1;
        bus.instr_done = bus.mem_ready;
      end
      S_R_EXEC:   bus.alu_src_a = 1'b1;
      S_R_WB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = REG_DST_RD;
        bus.instr_done = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.pc_write_cond = 1'b1;
        bus.pc_src        = PC_SRC_ALUOUT;
        bus.branch_ne     = (bus.opcode == OP_BNE);
        bus.instr_done    = 1'b1;
      end
      S_JUMP: begin
        bus.pc_write   = 1'b1;
        bus.pc_src     = PC_SRC_JUMP;
        bus.instr_done = 1'b1;
        if (bus.opcode == OP_JAL) begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = REG_DST_R31;
          bus.mem_to_reg = MEM_TO_REG_PC;
        end
      end
      S_I_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = ALU_SRC_B_IMM;
      end
      S_I_WB: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_TRAP:     bus.illegal = 1'b1;
      default:    bus.illegal = 1'b1;
    endcase
  end

endmodule
